fib_seq: RTL and testbench
==========================

# fib_seq

Parametrised Fibonacci-style sequence engine and the multi-cycle successor to the fixed-width Fibonacci counter. A request is latched on a start/busy/done handshake. The request carries seeds F(0) and F(1) and an index n. The block computes F(n) = F(n-1) + F(n-2) mod 2^W and raises a sticky overflow flag. An optional stream mode emits every term F(0)..F(n) on a valid/ready port with backpressure. It sits on the arithmetic-demo datapath, driven by the control FSM or the host register file.

## Interface
- W, 16, data width of seeds, terms and result (W >= 2)
- NW, 8, width of the index n (maximum index 2^NW - 1)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  request strobe; sampled only in IDLE
- abort  in  1  cancels a running request
- stream  in  1  mode select latched with start: 1 = emit all terms
- n  in  NW  index of requested term, latched with start
- seed0  in  W  F(0), latched with start
- seed1  in  W  F(1), latched with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  W  F(n) mod 2^W, held from done until next accept
- overflow  out  1  carry out of W bits occurred for some F(j), j <= n; valid with done, held with result
- term_valid  out  1  stream term available (stream mode, RUN only)
- term_ready  in  1  consumer accepts term
- term_data  out  W  current term F(k); 0 when term_valid = 0
- term_idx  out  NW  k of current term; 0 when term_valid = 0
- term_last  out  1  term_valid and k == n

## Operation
- States: IDLE, RUN, DONE.
- Registers: cur = F(k), nxt = F(k+1), k (NW bits), n_reg, stream_reg, ovf.
- IDLE: on start = 1, latch n, stream, seeds (cur = seed0, nxt = seed1), k = 0, ovf = 0, go to RUN.
- RUN, advance condition: stream_reg = 0 advances every cycle; stream_reg = 1 advances only on term_valid & term_ready.
- RUN, on advance with k != n_reg: cur <= nxt, nxt <= cur + nxt (W-bit wrap), k <= k + 1.
  - ovf is set if the addition carries and it produces a term of index <= n_reg, that is k + 2 <= n_reg.
  - The carry from nxt(k = 0) is seed1 and cannot overflow.
  - If n_reg >= 2, a carry is possible from F(2) onward.
- RUN, on advance with k == n_reg: result <= cur, overflow <= ovf, go to DONE.
- DONE: done = 1 for exactly this cycle, then unconditionally go to IDLE.
  - A start seen in DONE is ignored.
- Stream mode: term_valid = 1 throughout RUN with term_data = cur and term_idx = k.
  - term_data and term_idx stay stable while term_ready = 0.
  - The term with index n carries term_last = 1.
- start in RUN or DONE is ignored. No queuing.
- abort = 1 in RUN: go to IDLE at the next edge. No done is generated; result and overflow keep their previous values. abort in IDLE or DONE has no effect.
- abort and an advance on the same edge: abort wins.
- n = 0 returns seed0; n = 1 returns seed1; overflow = 0 in both cases.
- Inputs n, seed0, seed1 and stream may change freely after the accept edge.

## Timing
- Reset (async): state IDLE; busy, done, result, overflow, term_valid, term_data, term_idx, term_last all 0.
- The accept edge is E0. In non-stream mode RUN lasts n+1 cycles: busy is high from after E0 through after En.
- The DONE cycle follows. done is high in the (n+2)-th cycle after E0, and result is valid from that same cycle.
- Stream mode: RUN lasts n+1 handshake cycles plus any stall cycles. done follows the cycle of the last handshake.
- A next start is accepted no earlier than the cycle after DONE (IDLE). The minimum request-to-request period is n+3 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs, except term_data and term_idx, which follow registered cur and k.

## Test plan
- W=8, seeds 0/1, n=13, stream=0 -> done 15 cycles after accept, result=233, overflow=0; n=14 -> result=121, overflow=1.
- W=8, seeds 2/1 (Lucas), n=0 and n=1 -> result=2 then 1, overflow=0, done 2 and 3 cycles after accept; n=10 -> result=123.
- Stream, W=16, seeds 0/1, n=7, term_ready toggling 1/0 -> term_data sequence 0,1,1,2,3,5,8,13 with term_idx 0..7, term_last only on 13, values stable during stalls, done after final handshake, result=13.
- start pulsed during RUN and during DONE -> ignored; second start in IDLE -> new result computed with new seeds.
- abort asserted mid-RUN (n=20, after 5 cycles) -> IDLE next edge, no done, result/overflow retain prior values; new request then completes normally.
- reset asserted asynchronously mid-RUN in stream mode -> all outputs 0 immediately, busy=0, subsequent request completes correctly.

Source files
------------

// File: rtl/fib_seq.sv
// Multi-cycle Fibonacci-style sequence engine: F(n) = F(n-1) + F(n-2) mod 2^W from two seeds,
// with a sticky carry flag and an optional valid/ready stream of every term F(0)..F(n).
module fib_seq #(
  parameter int W  = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          stream_i,
  input  logic [NW-1:0] n_i,
  input  logic [W-1:0]  seed0_i,
  input  logic [W-1:0]  seed1_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [W-1:0]  result_o,
  output logic          overflow_o,
  output logic          term_valid_o,
  input  logic          term_ready_i,
  output logic [W-1:0]  term_data_o,
  output logic [NW-1:0] term_idx_o,
  output logic          term_last_o,
  output logic [1:0]    dbg_state_o
);

  // Handshakes: start is sampled only in IDLE; a stream term transfers on an edge where
  // term_valid_o and term_ready_i are both high, and term_data_o/term_idx_o hold until then.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  nxt_q, nxt_d;
  logic [NW-1:0] k_q, k_d;
  logic [NW-1:0] n_q, n_d;
  logic          stream_q, stream_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  result_q, result_d;
  logic          overflow_q, overflow_d;

  logic [W:0]    sum;
  logic [NW:0]   k_plus2;
  logic          advance;

  assign sum     = {1'b0, cur_q} + {1'b0, nxt_q};
  assign k_plus2 = {1'b0, k_q} + (NW+1)'(2);
  assign advance = !stream_q || term_ready_i;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    k_d        = k_q;
    n_d        = n_q;
    stream_d   = stream_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cur_d    = seed0_i;
          nxt_d    = seed1_i;
          k_d      = '0;
          n_d      = n_i;
          stream_d = stream_i;
          ovf_d    = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (advance) begin
          if (k_q == n_q) begin
            result_d   = cur_q;
            overflow_d = ovf_q;
            state_d    = ST_DONE;
          end else begin
            cur_d = nxt_q;
            nxt_d = sum[W-1:0];
            k_d   = k_q + NW'(1);
            // The sum becomes F(k+2); its carry only counts if that term is within the request.
            if (sum[W] && (k_plus2 <= {1'b0, n_q})) begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      k_q        <= '0;
      n_q        <= '0;
      stream_q   <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      k_q        <= k_d;
      n_q        <= n_d;
      stream_q   <= stream_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign result_o     = result_q;
  assign overflow_o   = overflow_q;
  assign term_valid_o = busy_o && stream_q;
  assign term_data_o  = term_valid_o ? cur_q : '0;
  assign term_idx_o   = term_valid_o ? k_q : '0;
  assign term_last_o  = term_valid_o && (k_q == n_q);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fib_seq.sv
// Bench for fib_seq: drives a W=16 and a W=8 instance with the same requests and checks both
// against an arithmetic Fibonacci model, a stimulus table and hand-written corner sequences.
module tb_fib_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, stream, term_ready;
  logic [7:0]  n;
  logic [15:0] seed0, seed1;

  logic        busy16, done16, ovf16, tv16, tl16;
  logic [15:0] res16, td16;
  logic [7:0]  ti16;
  logic [1:0]  st16;
  logic        busy8, done8, ovf8, tv8, tl8;
  logic [7:0]  res8, td8;
  logic [7:0]  ti8;
  logic [1:0]  st8;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  fib_seq #(.W(16), .NW(8)) u16 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .stream_i(stream),
    .n_i(n), .seed0_i(seed0), .seed1_i(seed1), .busy_o(busy16), .done_o(done16),
    .result_o(res16), .overflow_o(ovf16), .term_valid_o(tv16), .term_ready_i(term_ready),
    .term_data_o(td16), .term_idx_o(ti16), .term_last_o(tl16), .dbg_state_o(st16)
  );

  fib_seq #(.W(8), .NW(8)) u8 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .stream_i(stream),
    .n_i(n), .seed0_i(seed0[7:0]), .seed1_i(seed1[7:0]), .busy_o(busy8), .done_o(done8),
    .result_o(res8), .overflow_o(ovf8), .term_valid_o(tv8), .term_ready_i(term_ready),
    .term_data_o(td8), .term_idx_o(ti8), .term_last_o(tl8), .dbg_state_o(st8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Term j of the sequence reduced mod 2^w, plus whether any addition for F(2)..F(j) carried.
  function automatic void model(input int w, input int nn, input longint s0, input longint s1,
                                output longint res, output bit ovf);
    longint m, a, b, s;
    m   = longint'(1) << w;
    a   = s0 % m;
    b   = s1 % m;
    ovf = 1'b0;
    if (nn == 0) begin
      res = a;
    end else begin
      for (int j = 2; j <= nn; j++) begin
        s = a + b;
        if (s >= m) ovf = 1'b1;
        a = b;
        b = s % m;
      end
      res = b;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge right after the accept edge.
  task automatic accept(input int nn, input int s0, input int s1, input bit st);
    n      = nn[7:0];
    seed0  = s0[15:0];
    seed1  = s1[15:0];
    stream = st;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    n      = 8'($urandom);
    seed0  = 16'($urandom);
    seed1  = 16'($urandom);
    stream = 1'($urandom);
  endtask

  task automatic run_req(input int nn, input int s0, input int s1, input bit st, input int rmode,
                         input longint r8, input bit o8, input longint r16, input bit o16);
    int          cyc, h;
    bit          rdy, prev_stall, tovf;
    logic [15:0] prev_d, e;
    logic [7:0]  prev_i;
    longint      t;
    exp_q.delete();
    if (st) begin
      for (int j = 0; j <= nn; j++) begin
        model(16, j, s0, s1, t, tovf);
        exp_q.push_back(t[15:0]);
      end
    end
    accept(nn, s0, s1, st);
    cyc = 1; h = 0; rdy = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_i = '0;
    while (!done16 && cyc < 4 * nn + 40) begin
      chk("busy_run", busy16, 1);
      chk("term_valid", tv16, st);
      if (!st) begin
        chk("term_data_zero", td16, 0);
      end else if (exp_q.size() == 0) begin
        chk("extra_term", 1, 0);
      end else begin
        e = exp_q[0];
        if (prev_stall) begin
          chk("stall_data", td16, prev_d);
          chk("stall_idx", ti16, prev_i);
        end
        chk("term_data16", td16, e);
        chk("term_data8", td8, e[7:0]);
        chk("term_idx", ti16, h);
        chk("term_last", tl16, (h == nn));
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = !rdy;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        term_ready = rdy;
        if (rdy) begin
          void'(exp_q.pop_front());
          h++;
        end
        prev_stall = !rdy;
        prev_d     = td16;
        prev_i     = ti16;
      end
      @(negedge clk);
      cyc++;
    end
    term_ready = 1'b0;
    if (!done16) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (!st) chk("done_latency", cyc, nn + 2);
      chk("done8", done8, 1);
      chk("result16", res16, r16);
      chk("overflow16", ovf16, o16);
      chk("result8", res8, r8);
      chk("overflow8", ovf8, o8);
      if (st) chk("terms_left", exp_q.size(), 0);
    end
    @(negedge clk);
    chk("idle_busy", busy16, 0);
    chk("done_pulse", done16, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy16, 0);
    chk({tag, "_done"}, done16, 0);
    chk({tag, "_result"}, res16, 0);
    chk({tag, "_overflow"}, ovf16, 0);
    chk({tag, "_tvalid"}, tv16, 0);
    chk({tag, "_tdata"}, td16, 0);
    chk({tag, "_tidx"}, ti16, 0);
    chk({tag, "_tlast"}, tl16, 0);
    chk({tag, "_result8"}, res8, 0);
  endtask

  typedef struct {
    int     nn;
    int     s0;
    int     s1;
    bit     st;
    int     rmode;
    longint r8;
    bit     o8;
    longint r16;
    bit     o16;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int     cyc;
    bit     saw_done, st, o8, o16;
    int     nn, s0, s1;
    longint r8, r16;

    vecs[0] = '{13,  0,   1, 1'b0, 0, 233, 1'b0, 233, 1'b0};
    vecs[1] = '{14,  0,   1, 1'b0, 0, 121, 1'b1, 377, 1'b0};
    vecs[2] = '{0,   2,   1, 1'b0, 0,   2, 1'b0,   2, 1'b0};
    vecs[3] = '{1,   2,   1, 1'b0, 0,   1, 1'b0,   1, 1'b0};
    vecs[4] = '{10,  2,   1, 1'b0, 0, 123, 1'b0, 123, 1'b0};
    vecs[5] = '{7,   0,   1, 1'b1, 1,  13, 1'b0,  13, 1'b0};
    vecs[6] = '{2, 200, 100, 1'b0, 0,  44, 1'b1, 300, 1'b0};
    vecs[7] = '{1, 200, 200, 1'b0, 0, 200, 1'b0, 200, 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; stream = 1'b0; term_ready = 1'b0;
    n = '0; seed0 = '0; seed1 = '0;
    #1;
    check_zero_outputs("reset");
    chk("reset_state", st16, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_req(vecs[i].nn, vecs[i].s0, vecs[i].s1, vecs[i].st, vecs[i].rmode,
              vecs[i].r8, vecs[i].o8, vecs[i].r16, vecs[i].o16);
    end

    // start during RUN and during DONE must not disturb or restart the request
    accept(5, 3, 4, 1'b0);
    n = 8'd2; seed0 = 16'd100; seed1 = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ignore_done_seen", done16, 1);
    chk("ignore_result", res16, 29);
    n = 8'd1; seed0 = 16'd9; seed1 = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_done_start_busy", busy16, 0);
    @(negedge clk);
    chk("ignore_done_start_busy2", busy16, 0);
    chk("ignore_done_start_done", done16, 0);
    run_req(3, 9, 9, 1'b0, 0, 27, 1'b0, 27, 1'b0);

    // abort mid-RUN: no done, previous result and overflow retained
    run_req(14, 0, 1, 1'b0, 0, 121, 1'b1, 377, 1'b0);
    accept(20, 5, 7, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy16, 0);
    saw_done = 1'b0;
    repeat (25) begin
      if (done16 || busy16) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_result16", res16, 377);
    chk("abort_overflow8", ovf8, 1);
    chk("abort_result8", res8, 121);
    run_req(6, 1, 1, 1'b0, 0, 13, 1'b0, 13, 1'b0);

    // asynchronous reset in the middle of a stream request
    accept(10, 0, 1, 1'b1);
    term_ready = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    term_ready = 1'b0;
    @(negedge clk);
    run_req(10, 0, 1, 1'b1, 2, 55, 1'b0, 55, 1'b0);

    // randomized requests against the model
    for (int i = 0; i < 14; i++) begin
      nn = $urandom_range(0, 30);
      s0 = $urandom_range(0, 65535);
      s1 = $urandom_range(0, 65535);
      st = 1'($urandom_range(0, 1));
      model(8, nn, s0, s1, r8, o8);
      model(16, nn, s0, s1, r16, o16);
      run_req(nn, s0, s1, st, 2, r8, o8, r16, o16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
